// File: rtl/edge_addr_seq_if.sv
// Memory request/acknowledge bus between the 3x3 window address sequencer
// and the memory side. The master drives requests and the slave returns mem_ack.
interface edge_addr_seq_if #(
  parameter int ADDR_W = 32
) ();
  logic              mem_req;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        win_idx;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_write,
    output mem_addr,
    output win_idx,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_write,
    input  mem_addr,
    input  win_idx,
    output mem_ack
  );
endinterface

// File: rtl/edge_addr_seq.sv
// Address sequencer for a 3x3 window filter: it issues nine window reads and one
// result write per output pixel, and it walks the whole (W-2)x(H-2) output image.
module edge_addr_seq #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_raddr,
  input  logic [ADDR_W-1:0] start_waddr,
  input  logic [15:0]       img_width,
  input  logic [15:0]       img_height,
  edge_addr_seq_if.master   mem,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       w_q, w_d;
  logic [15:0]       h_q, h_d;
  logic [15:0]       r_q, r_d;
  logic [15:0]       c_q, c_d;
  logic [3:0]        k_q, k_d;
  logic [1:0]        kc_q, kc_d;
  logic [ADDR_W-1:0] rrow_q, rrow_d;
  logic [ADDR_W-1:0] wrow_q, wrow_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        win_idx_q, win_idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              ack_hit;
  logic [ADDR_W-1:0] w_ext;

  assign ack_hit = mem_req_q & mem.mem_ack;
  assign w_ext   = ADDR_W'(w_q);

  // rrow/wrow hold raddr + r*W and waddr + r*(W-2). kc is k%3. Each read address
  // is derived from the previous one, so no multiplier is needed.
  always_comb begin
    state_d     = state_q;
    raddr_d     = raddr_q;
    waddr_d     = waddr_q;
    w_d         = w_q;
    h_d         = h_q;
    r_d         = r_q;
    c_d         = c_q;
    k_d         = k_q;
    kc_d        = kc_q;
    rrow_d      = rrow_q;
    wrow_d      = wrow_q;
    mem_req_d   = mem_req_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    win_idx_d   = win_idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          raddr_d = start_raddr;
          waddr_d = start_waddr;
          w_d     = img_width;
          h_d     = img_height;
          r_d     = 16'd0;
          c_d     = 16'd0;
          k_d     = 4'd0;
          kc_d    = 2'd0;
          rrow_d  = start_raddr;
          wrow_d  = start_waddr;
          if ((img_width < 16'd3) || (img_height < 16'd3)) begin
            state_d = FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d     = READ;
            mem_req_d   = 1'b1;
            mem_write_d = 1'b0;
            mem_addr_d  = start_raddr;
            win_idx_d   = 4'd0;
            busy_d      = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (ack_hit) begin
          if (k_q == 4'd8) begin
            state_d     = WRITE;
            k_d         = 4'd0;
            kc_d        = 2'd0;
            mem_write_d = 1'b1;
            win_idx_d   = 4'd9;
            mem_addr_d  = wrow_q + ADDR_W'(c_q);
          end else begin
            k_d       = k_q + 4'd1;
            win_idx_d = k_q + 4'd1;
            if (kc_q == 2'd2) begin
              kc_d       = 2'd0;
              mem_addr_d = mem_addr_q + w_ext - ADDR_W'(2'd2);
            end else begin
              kc_d       = kc_q + 2'd1;
              mem_addr_d = mem_addr_q + ADDR_W'(1'b1);
            end
          end
        end else begin
          state_d = READ;
        end
      end
      WRITE: begin
        if (ack_hit) begin
          mem_write_d = 1'b0;
          win_idx_d   = 4'd0;
          if ((c_q == w_q - 16'd3) && (r_q == h_q - 16'd3)) begin
            state_d   = FIN;
            mem_req_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else if (c_q == w_q - 16'd3) begin
            state_d    = READ;
            c_d        = 16'd0;
            r_d        = r_q + 16'd1;
            rrow_d     = rrow_q + w_ext;
            wrow_d     = wrow_q + w_ext - ADDR_W'(2'd2);
            mem_addr_d = rrow_q + w_ext;
          end else begin
            state_d    = READ;
            c_d        = c_q + 16'd1;
            mem_addr_d = rrow_q + ADDR_W'(c_q) + ADDR_W'(1'b1);
          end
        end else begin
          state_d = WRITE;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // Every piece of state and every output is registered here, with asynchronous clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      raddr_q     <= '0;
      waddr_q     <= '0;
      w_q         <= 16'd0;
      h_q         <= 16'd0;
      r_q         <= 16'd0;
      c_q         <= 16'd0;
      k_q         <= 4'd0;
      kc_q        <= 2'd0;
      rrow_q      <= '0;
      wrow_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      win_idx_q   <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
      w_q         <= w_d;
      h_q         <= h_d;
      r_q         <= r_d;
      c_q         <= c_d;
      k_q         <= k_d;
      kc_q        <= kc_d;
      rrow_q      <= rrow_d;
      wrow_q      <= wrow_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      win_idx_q   <= win_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_write = mem_write_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.win_idx   = win_idx_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: doc/edge_addr_seq.md
EDGE_ADDR_SEQ -- requirements
Module: edge_addr_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have port clk  input  1  system clock, rising-edge.
REQ-003 SHALL have port n_rst  input  1  reset; one clock, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle job start pulse.
REQ-005 SHALL have port start_raddr  input  ADDR_W  source image base address.
REQ-006 SHALL have port start_waddr  input  ADDR_W  result image base address.
REQ-007 SHALL have port img_width  input  16  source width W, pixels.
REQ-008 SHALL have port img_height  input  16  source height H, pixels.
REQ-009 SHALL have port mem_ack  input  1  memory accepts current request.
REQ-010 SHALL have port mem_req  output  1  memory request valid.
REQ-011 SHALL have port mem_write  output  1  1 = result write, 0 = window read.
REQ-012 SHALL have port mem_addr  output  ADDR_W  request byte address.
REQ-013 SHALL have port win_idx  output  4  window slot 0-8 for reads; 9 for writes.
REQ-014 SHALL have port busy  output  1  job in progress.
REQ-015 SHALL have port done  output  1  one-cycle job completion pulse.
REQ-016 SHALL have port err  output  1  one-cycle bad-dimension pulse, coincident with done.

Function
REQ-017 SHALL implement FSM states IDLE, READ, WRITE, FIN; all outputs registered.
REQ-018 SHALL, in IDLE on start, latch start_raddr, start_waddr, img_width, img_height; clear row r, col c, slot k.
REQ-019 SHALL, if latched W<3 or H<3, go to FIN with err=1 and issue no request.
REQ-020 SHALL otherwise enter READ: mem_req=1 and busy=1 in the cycle after start.
REQ-021 SHALL drive READ address raddr + (r+k/3)*W + (c+k%3), win_idx=k, mem_write=0.
REQ-022 SHALL compute addresses modulo 2^ADDR_W, wrap silently; multiply via running row-offset accumulators.
REQ-023 SHALL hold mem_req, mem_addr, mem_write, win_idx stable until a cycle with mem_req=1 and mem_ack=1.
REQ-024 SHALL, on each READ ack, increment k; after ack of k=8, go to WRITE with next request on following cycle.
REQ-025 SHALL drive WRITE address waddr + r*(W-2) + c, win_idx=9, mem_write=1.
REQ-026 SHALL, on WRITE ack, advance c; if c=W-3, set c=0 and advance r; reset k=0; return to READ.
REQ-027 SHALL, on WRITE ack with r=H-3 and c=W-3, go to FIN.
REQ-028 SHALL, in FIN, pulse done=1 for one cycle, set busy=0 and mem_req=0, then return to IDLE.
REQ-029 SHALL issue exactly 10*(W-2)*(H-2) accepted requests per valid job, back-to-back when mem_ack is held high.
REQ-030 SHALL ignore mem_ack while mem_req=0.
REQ-031 SHALL ignore start while busy=1 or in FIN; a new start is accepted the cycle after done.
REQ-032 SHALL leave latched parameters unaffected by input changes during a job.

Reset
REQ-033 SHALL, on n_rst low at any time including mid-job, immediately force IDLE, mem_req=0, mem_write=0, mem_addr=0, win_idx=0, busy=0, done=0, err=0, and clear all counters and latches.
REQ-034 SHALL require a new start after reset release; an aborted job is never resumed and produces no done.

Verification
REQ-035 SHALL pass: W=3, H=3, raddr=0x1000, waddr=0x2000, mem_ack=1 -> reads 0x1000,0x1001,0x1002,0x1003,0x1004,0x1005,0x1006,0x1007,0x1008, write 0x2000, done 1 cycle after the write ack.
REQ-036 SHALL pass: W=4, H=3, same bases -> window 2 reads 0x1001,0x1002,0x1003,0x1005,0x1006,0x1007,0x1009,0x100A,0x100B, writes 0x2000 then 0x2001, 20 requests total.
REQ-037 SHALL pass: W=2, H=5, start -> done=1 and err=1 one cycle after start, mem_req never high.
REQ-038 SHALL pass: W=3, H=3, mem_ack low 5 cycles on slot 4 -> mem_addr 0x1004 held stable 6 cycles, sequence otherwise unchanged.
REQ-039 SHALL pass: W=3, H=3, raddr=0xFFFFFFFE -> reads 0xFFFFFFFE,0xFFFFFFFF,0x00000000,... with wrap.
REQ-040 SHALL pass: n_rst low during slot 5 of W=5, H=5 job -> all outputs 0 same cycle, no done; new start with W=3, H=3 runs as REQ-035.
